// File: rtl/rx_flow_pkg.sv
// Shared types, defaults and parameter checks for the UART-to-JTAG receive buffer.
// Included first so the parameter-check macro is visible to every rx_flow file.
`ifndef RX_FLOW_PKG_SV
`define RX_FLOW_PKG_SV

`define RX_FLOW_PARAM_CHECK(D, LO, HI) \
  if ((((D) & ((D) - 1)) != 0) || ((D) < 4) || ((LO) >= (HI)) || ((HI) > (D))) begin : g_bad_params \
    $error("rx_flow_fifo: DEPTH must be a power of two >= 4 and LO_WATER < HI_WATER <= DEPTH"); \
  end

package rx_flow_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_CNT_W = 16;
  // Default watermarks are derived from DEPTH: HI = DEPTH - HI_MARGIN, LO = DEPTH / LO_DIV.
  localparam int HI_MARGIN = 16;
  localparam int LO_DIV    = 4;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`endif

// File: rtl/fifo_mem_2p.sv
// WIDTH x DEPTH storage array: synchronous write port, asynchronous (combinational) read port.
// A write at edge N is visible on rd_data right after that edge.
module fifo_mem_2p
  import rx_flow_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rx_flow_fifo.sv
// FWFT receive FIFO with RTS watermark hysteresis, drop-on-full accounting and synchronous flush.
// Write-to-read latency one cycle; writer stalls via rx_ready (DROP_ON_FULL=0) or words are dropped.
module rx_flow_fifo
  import rx_flow_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int HI_WATER     = DEPTH - HI_MARGIN,
  parameter int LO_WATER     = DEPTH / LO_DIV,
  parameter int DROP_ON_FULL = 1,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      empty,
  output logic                      full,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic [lvl_w(DEPTH)-1:0]   free,
  input  logic                      flush,
  output logic                      rts_n,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_cnt,
  input  logic                      clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_HI   = LW'(HI_WATER);
  localparam logic [LW-1:0] LVL_LO   = LW'(LO_WATER);
  localparam logic          DROP_EN  = (DROP_ON_FULL != 0);

  `RX_FLOW_PARAM_CHECK(DEPTH, LO_WATER, HI_WATER)

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          accept;
  logic          drop;
  logic          wr_en;
  logic [LW-1:0] next_level;
  logic          next_rts;

  assign empty  = (level == '0);
  assign full   = (level == LVL_FULL);
  assign free   = LVL_FULL - level;
  assign pop    = rd_en && !empty;
  assign accept = rx_valid && (!full || pop);
  // A write thrown away by a same-cycle flush is not an overflow event.
  assign drop   = DROP_EN && rx_valid && full && !pop && !flush;
  // In stall mode ready sees rd_en combinationally so a full FIFO can pass-through in one cycle.
  assign rx_ready = DROP_EN ? 1'b1 : (!full || pop);
  assign wr_en  = accept && !flush;

  always_comb begin
    next_level = level;
    if (flush) begin
      next_level = '0;
    end else if (accept && !pop) begin
      next_level = level + LW'(1);
    end else if (pop && !accept) begin
      next_level = level - LW'(1);
    end
  end

  always_comb begin
    next_rts = rts_n;
    if (next_level >= LVL_HI) begin
      next_rts = 1'b1;
    end else if (next_level <= LVL_LO) begin
      next_rts = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rts_n  <= 1'b0;
    end else begin
      level <= next_level;
      rts_n <= next_rts;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + AW'(1);
        if (pop)    rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Clear beats a coincident drop: software sees a clean zero after clr_ovf.
  always_ff @(posedge clk) begin
    if (rst || clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (rx_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule
